// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the pmem line-port arbiter
package rv32i_types;

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} arb_src_t;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational requester pick for mem_arbiter
// MEM_ARBITER_RR_EN selects round-robin ties; otherwise D-cache has fixed priority.
module mem_arb_pick
  import rv32i_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_grant,
  output logic     grant_valid,
  output arb_src_t grant_src
);

  assign grant_valid = i_req | d_req;

`ifdef MEM_ARBITER_RR_EN
  always_comb begin
    if (i_req && d_req) begin
      grant_src = (last_grant == DCACHE) ? ICACHE : DCACHE;
    end else begin
      grant_src = d_req ? DCACHE : ICACHE;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = (last_grant == DCACHE);

  always_comb begin
    grant_src = d_req ? DCACHE : ICACHE;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one pmem line port between I-cache and D-cache
// Tie policy selected by MEM_ARBITER_RR_EN (see mem_arb_pick).
module mem_arbiter #(
  parameter int LINE_W = rv32i_types::LINE_W,
  parameter int ADDR_W = rv32i_types::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  import rv32i_types::*;

  arb_state_t        r_state, w_next_state;
  arb_src_t          r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_dir_write;
  logic [LINE_W-1:0] r_i_rdata, r_d_rdata;
  logic              w_grant_valid;
  arb_src_t          w_grant_src;
  logic              w_grant;

  mem_arb_pick u_pick (
    .i_req       (i_read),
    .d_req       (d_read | d_write),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_src   (w_grant_src)
  );

  assign w_grant = (r_state == IDLE) && w_grant_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = (w_grant_src == DCACHE) ? BUSY_D : BUSY_I;
      BUSY_I:  if (pmem_resp) w_next_state = RESP_I;
      BUSY_D:  if (pmem_resp) w_next_state = RESP_D;
      RESP_I:  w_next_state = IDLE;
      RESP_D:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= DCACHE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_dir_write  <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_last_grant <= w_grant_src;
        r_addr       <= (w_grant_src == DCACHE) ? d_addr : i_addr;
        r_wdata      <= (w_grant_src == DCACHE) ? d_wdata : r_wdata;
        // a simultaneous read+write from the D-cache is served as the write
        r_dir_write  <= (w_grant_src == DCACHE) && d_write;
      end
      if (pmem_resp && !r_dir_write) begin
        if (r_state == BUSY_I) r_i_rdata <= pmem_rdata;
        if (r_state == BUSY_D) r_d_rdata <= pmem_rdata;
      end
    end
  end

  // strobes decode from the state register so reset removes them immediately
  assign pmem_read  = ((r_state == BUSY_I) || (r_state == BUSY_D)) && !r_dir_write;
  assign pmem_write = (r_state == BUSY_D) && r_dir_write;
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;
  assign i_resp     = (r_state == RESP_I);
  assign d_resp     = (r_state == RESP_D);
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;

endmodule
